// File: rtl/route_compute_scheduler.sv
// -----------------------------------------------------------------------------
// route_compute_scheduler
//
// Purpose:
//   Shares one route-computation unit among P router input ports. Each port
//   raises rc_req with its header-flit destination address. A round-robin
//   winner's address is registered onto ru_dest_addr and held for RU_LAT
//   cycles. The unit's answer is then registered into rc_destport and
//   returned with a single-cycle one-hot rc_ack.
//
// Optional feature (macro RC_LAST_DEST_CACHE_EN):
//   A one-entry cache remembers the last computed {addr, destport}. A winner
//   whose address hits the cache skips COMPUTE and is acked one cycle after
//   being granted. Without the macro, every request goes through COMPUTE.
//
// Parameters:
//   P       number of requesting input ports (>=2)
//   DAw     destination endpoint address width
//   DSTPw   encoded destination-port width from the routing unit
//   RU_LAT  cycles ru_dest_addr is held before ru_destport is valid (1..15)
//
// Ports:
//   clk           clock
//   reset         synchronous, active-high reset
//   rc_req        per-port request, held until the matching rc_ack
//   rc_dest_addr  per-port destination address, slice i = [(i+1)*DAw-1:i*DAw]
//   rc_ack        one-hot single-cycle pulse, result valid for that port
//   rc_destport   registered result, valid only while rc_ack != 0
//   rc_busy       high whenever the scheduler is not idle
//   ru_dest_addr  registered address driven to the shared routing unit
//   ru_destport   routing-unit result for ru_dest_addr
// -----------------------------------------------------------------------------
module route_compute_scheduler #(
  parameter int P      = 5,
  parameter int DAw    = 8,
  parameter int DSTPw  = 4,
  parameter int RU_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [P-1:0]         rc_req,
  input  logic [P*DAw-1:0]     rc_dest_addr,
  output logic [P-1:0]         rc_ack,
  output logic [DSTPw-1:0]     rc_destport,
  output logic                 rc_busy,
  output logic [DAw-1:0]       ru_dest_addr,
  input  logic [DSTPw-1:0]     ru_destport
);

  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam logic [3:0] CNT_INIT = 4'(RU_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } state_t;

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    winner;
  logic [3:0]       cnt;
  logic [P-1:0]     ack_q;

  logic             found;
  logic [PW-1:0]    pick;
  logic [PW:0]      sum;
  logic [PW-1:0]    cand;
  logic [DAw-1:0]   pick_addr;

  logic             take_cache;
  logic [DSTPw-1:0] cached_dp;

  // Round-robin pick: scan ports starting at the pointer, wrapping modulo P,
  // so the pointer position has highest priority.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < P; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(P)) begin
        sum = sum - (PW+1)'(P);
      end
      cand = sum[PW-1:0];
      if (!found && rc_req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign pick_addr = rc_dest_addr[int'(pick)*DAw +: DAw];

`ifdef RC_LAST_DEST_CACHE_EN
  logic             cache_valid;
  logic [DAw-1:0]   cache_addr;
  logic [DSTPw-1:0] cache_dp;

  // The cache is refreshed on every result captured from the routing unit;
  // cache hits do not rewrite it since the entry is already current.
  always_ff @(posedge clk) begin
    if (reset) begin
      cache_valid <= 1'b0;
      cache_addr  <= '0;
      cache_dp    <= '0;
    end else if (state == COMPUTE && rc_req[winner] && cnt == 4'd0) begin
      cache_valid <= 1'b1;
      cache_addr  <= ru_dest_addr;
      cache_dp    <= ru_destport;
    end
  end

  assign take_cache = cache_valid && (cache_addr == pick_addr);
  assign cached_dp  = cache_dp;
`else
  assign take_cache = 1'b0;
  assign cached_dp  = '0;
`endif

  // Scheduler FSM. ack_q is raised on entry to DONE, so it is high for
  // exactly the DONE cycle. An abort in COMPUTE leaves the pointer and
  // rc_destport untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= '0;
      winner       <= '0;
      cnt          <= '0;
      ack_q        <= '0;
      rc_destport  <= '0;
      rc_busy      <= 1'b0;
      ru_dest_addr <= '0;
    end else begin
      ack_q <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            winner  <= pick;
            rc_busy <= 1'b1;
            if (take_cache) begin
              rc_destport <= cached_dp;
              ack_q       <= P'(1) << pick;
              state       <= DONE;
            end else begin
              ru_dest_addr <= pick_addr;
              cnt          <= CNT_INIT;
              state        <= COMPUTE;
            end
          end
        end
        COMPUTE: begin
          if (!rc_req[winner]) begin
            state   <= IDLE;
            rc_busy <= 1'b0;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rc_destport <= ru_destport;
            ack_q       <= P'(1) << winner;
            state       <= DONE;
          end
        end
        DONE: begin
          ptr     <= (winner == PW'(P-1)) ? '0 : winner + 1'b1;
          state   <= IDLE;
          rc_busy <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          rc_busy <= 1'b0;
        end
      endcase
    end
  end

  // Gating with rc_req guarantees no ack reaches a port that has already
  // withdrawn its request in the DONE cycle.
  assign rc_ack = ack_q & rc_req;

endmodule

// File: tb/tb_route_compute_scheduler.sv
// -----------------------------------------------------------------------------
// tb_route_compute_scheduler
//
// Purpose:
//   Self-checking bench for route_compute_scheduler with P=5, RU_LAT=2. A
//   model routing unit returns ru_dest_addr[3:0] only once the address has
//   been stable for two cycles, and a deliberately wrong value before that.
//   Expected acks are queued when a request is driven and popped when the
//   DUT acks. Build with RC_LAST_DEST_CACHE_EN to exercise the cached path.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_route_compute_scheduler;

  localparam int P      = 5;
  localparam int DAw    = 8;
  localparam int DSTPw  = 4;
  localparam int RU_LAT = 2;

`ifdef RC_LAST_DEST_CACHE_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 3;
`endif

  typedef struct {
    int         port;
    logic [3:0] dp;
    int         cyc;
  } exp_t;

  logic               clk;
  logic               reset;
  logic [P-1:0]       rc_req;
  logic [P*DAw-1:0]   rc_dest_addr;
  logic [P-1:0]       rc_ack;
  logic [DSTPw-1:0]   rc_destport;
  logic               rc_busy;
  logic [DAw-1:0]     ru_dest_addr;
  logic [DSTPw-1:0]   ru_destport;

  logic [DAw-1:0]     ru_hist;
  logic [P-1:0]       last_ack;
  bit                 auto_drop;
  int                 cyc;
  int                 err_count;
  int                 check_count;
  exp_t               exp_q[$];

  route_compute_scheduler #(
    .P(P), .DAw(DAw), .DSTPw(DSTPw), .RU_LAT(RU_LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rc_req(rc_req),
    .rc_dest_addr(rc_dest_addr),
    .rc_ack(rc_ack),
    .rc_destport(rc_destport),
    .rc_busy(rc_busy),
    .ru_dest_addr(ru_dest_addr),
    .ru_destport(ru_destport)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model routing unit: the answer becomes correct only after the address
  // has been held for a second cycle; a premature capture sees ~addr[3:0].
  always @(posedge clk) ru_hist <= ru_dest_addr;
  assign ru_destport = (ru_dest_addr == ru_hist) ? ru_dest_addr[3:0] : ~ru_dest_addr[3:0];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expectAck(input int port, input logic [3:0] dp, input int at_cyc);
    exp_t e;
    e.port = port;
    e.dp   = dp;
    e.cyc  = at_cyc;
    exp_q.push_back(e);
  endtask

  task automatic setAddr(input int port, input logic [DAw-1:0] addr);
    rc_dest_addr[port*DAw +: DAw] = addr;
  endtask

  // One clock; acked requesters withdraw just after the edge ending DONE.
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    if (auto_drop) rc_req = rc_req & ~last_ack;
  endtask

  // Starts a phase: the current cycle becomes cycle 0 with req driven.
  task automatic applyStimulus(input logic [P-1:0] req);
    cyc    = 0;
    rc_req = req;
  endtask

  task automatic stepN(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Scoreboard consumer: every ack must match the head of the queue.
  always @(negedge clk) begin
    last_ack = rc_ack;
    if (rc_ack !== '0) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_ack", 32'(rc_ack), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("ack_port", 32'(rc_ack), 32'(5'b00001 << e.port));
        checkOutput("ack_destport", 32'(rc_destport), 32'(e.dp));
        checkOutput("ack_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    err_count    = 0;
    check_count  = 0;
    cyc          = 0;
    auto_drop    = 1'b1;
    last_ack     = '0;
    reset        = 1'b1;
    rc_req       = '0;
    rc_dest_addr = '0;
    stepN(2);
    reset = 1'b0;
    checkOutput("reset_ack", 32'(rc_ack), 32'd0);
    checkOutput("reset_destport", 32'(rc_destport), 32'd0);
    checkOutput("reset_busy", 32'(rc_busy), 32'd0);
    checkOutput("reset_ru_addr", 32'(ru_dest_addr), 32'd0);

    // Single request from port 2: full latency, ack in cycle 3.
    setAddr(2, 8'h1A);
    expectAck(2, 4'hA, 3);
    applyStimulus(5'b00100);
    step();
    checkOutput("t1_ru_addr", 32'(ru_dest_addr), 32'h1A);
    checkOutput("t1_busy_c1", 32'(rc_busy), 32'd1);
    stepN(3);
    checkOutput("t1_busy_c4", 32'(rc_busy), 32'd0);
    checkOutput("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Pointer now 3: port 3 first, then wrap to port 0.
    setAddr(3, 8'h27);
    setAddr(0, 8'h4C);
    expectAck(3, 4'h7, 3);
    expectAck(0, 4'hC, 7);
    applyStimulus(5'b01001);
    stepN(8);
    checkOutput("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Back to pointer 0, then all ports saturating.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    setAddr(0, 8'h51);
    setAddr(1, 8'h62);
    setAddr(2, 8'h73);
    setAddr(3, 8'h84);
    setAddr(4, 8'h95);
    for (int i = 0; i < 6; i++) begin
      expectAck(i % P, 4'((i % P) + 1), 3 + 4*i);
    end
    auto_drop = 1'b0;
    applyStimulus(5'b11111);
    stepN(24);
    rc_req    = '0;
    auto_drop = 1'b1;
    step();
    checkOutput("t2_busy_end", 32'(rc_busy), 32'd0);
    checkOutput("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // Abort: port 1 withdraws in its first COMPUTE cycle (pointer is 1).
    applyStimulus(5'b00010);
    step();
    checkOutput("t4_busy_compute", 32'(rc_busy), 32'd1);
    rc_req = '0;
    step();
    checkOutput("t4_busy_abort", 32'(rc_busy), 32'd0);
    stepN(3);
    // Pointer must still be 1, so port 1 beats port 2.
    expectAck(1, 4'h2, 3);
    expectAck(2, 4'h3, 7);
    applyStimulus(5'b00110);
    stepN(8);
    checkOutput("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset pulse in the middle of COMPUTE.
    applyStimulus(5'b00001);
    step();
    checkOutput("t4_ru_addr_pre", 32'(ru_dest_addr), 32'h51);
    reset = 1'b1;
    step();
    checkOutput("t4_rst_ack", 32'(rc_ack), 32'd0);
    checkOutput("t4_rst_destport", 32'(rc_destport), 32'd0);
    checkOutput("t4_rst_busy", 32'(rc_busy), 32'd0);
    checkOutput("t4_rst_ru_addr", 32'(ru_dest_addr), 32'd0);
    reset  = 1'b0;
    rc_req = '0;
    stepN(4);

    // Same address twice from port 1, then a different address.
    setAddr(1, 8'h33);
    expectAck(1, 4'h3, 3);
    applyStimulus(5'b00010);
    stepN(4);
    expectAck(1, 4'h3, HIT_LAT);
    applyStimulus(5'b00010);
    stepN(4);
    setAddr(1, 8'h3E);
    expectAck(1, 4'hE, 3);
    applyStimulus(5'b00010);
    stepN(4);
    checkOutput("t5_busy_end", 32'(rc_busy), 32'd0);
    checkOutput("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
